// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants and the IF/ID payload type
package pipeline_pkg;

  localparam int          DATA_WIDTH  = 32;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_LOAD = 7'd3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with enable, flush and sync active-low reset
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = RV_NOP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t data_q;
  if_id_t bubble;

  always_comb begin
    bubble          = '0;
    bubble.instr    = NOP_INSTR;
  end

  // Flush beats a held (disabled) register so a redirect always kills the fetched slot
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      data_q <= bubble;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch: PC register, next-PC mux, IF/ID register
// Optional FETCH_PERF_EN adds saturating stall/flush counters StallCntF/FlushCntF.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCen,
  input  logic                  Fen,
  input  logic                  Den,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic                  MisalignF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           StallCntF,
  output logic [31:0]           FlushCntF
`endif
);

  import pipeline_pkg::if_id_t;

  logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic                  misalign_q, misalign_d;
  if_id_t                if_id_d, if_id_q;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // Redirect wins over a stall so a resolved branch is never dropped
  always_comb begin
    pc_d = pc_q;
    if (PCSrcE) begin
      pc_d = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
    end else if (PCen) begin
      pc_d = pc_plus4;
    end
  end

  assign misalign_d = PCSrcE & (|PCTargetE[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    if_id_d          = '0;
    if_id_d.instr    = InstrF;
    if_id_d.pc       = pc_q;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.valid    = 1'b1;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (Den),
    .flush_i (PCSrcE),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  assign PCF       = pc_q;
  assign InstrD    = if_id_q.instr;
  assign PCD       = if_id_q.pc;
  assign PCPlus4D  = if_id_q.pc_plus4;
  assign ValidD    = if_id_q.valid;
  assign MisalignF = misalign_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PCSrcE && !Fen && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (PCSrcE && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCntF = stall_cnt_q;
  assign FlushCntF = flush_cnt_q;
`else
  // Fen only feeds the performance counters
  logic unused_fen;
  assign unused_fen = Fen;
`endif

endmodule
